// File: rtl/prio_select_pipe.sv
// prio_select_pipe
// Lowest-index (or rotating-priority) lane grant over M candidate words, with the
// prefix search split across STAGES register stages. Each stage resolves one
// contiguous segment of ceil(M/STAGES) lanes. It takes a 'found' carry from the
// previous stage, so a lane in a later segment can win only when no earlier
// segment already granted.
// The pipe stalls as a whole: every stage advances when the output is empty or
// being accepted, and holds otherwise. Bubbles are kept in place.
// Optional feature: define PRIO_SEL_ROUND_ROBIN_EN for rotating priority. Each
// beat samples the pointer when it is accepted, and the pointer moves past the
// granted lane on every output handshake that had a hit.
module prio_select_pipe #(
    parameter int M      = 8,
    parameter int N      = 16,
    parameter int STAGES = 2,
    localparam int IW    = $clog2(M)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [M-1:0]    i_mask,
    input  logic [M*N-1:0]  i_chi,
    output logic            o_valid,
    input  logic            o_ready,
    output logic            o_hit,
    output logic [IW-1:0]   o_idx,
    output logic [N-1:0]    o_y,
    output logic [M-1:0]    o_mask_rem,
    output logic [M*N-1:0]  o_chi
);

    localparam int SEG = (M + STAGES - 1) / STAGES;
    localparam int L   = STAGES - 1;

    logic            adv;

    logic            v_q     [STAGES];
    logic            found_q [STAGES];
    logic [IW-1:0]   idx_q   [STAGES];
    logic [N-1:0]    y_q     [STAGES];
    logic [M-1:0]    mask_q  [STAGES];
    logic [M*N-1:0]  chi_q   [STAGES];

    // Stage inputs: stage 0 is fed from the port, and every later stage from the previous register.
    logic            found_in [STAGES];
    logic [IW-1:0]   idx_in   [STAGES];
    logic [N-1:0]    y_in     [STAGES];
    logic [M-1:0]    mask_in  [STAGES];
    logic [M*N-1:0]  chi_in   [STAGES];
    logic [IW-1:0]   ptr_in   [STAGES];

    logic            found_d  [STAGES];
    logic [IW-1:0]   idx_d    [STAGES];
    logic [N-1:0]    y_d      [STAGES];
    logic [M-1:0]    mask_d   [STAGES];

`ifdef PRIO_SEL_ROUND_ROBIN_EN
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_q    [STAGES];
`endif

    assign adv        = !v_q[L] || o_ready;
    assign i_ready    = adv;
    assign o_valid    = v_q[L];
    assign o_hit      = found_q[L];
    assign o_idx      = idx_q[L];
    assign o_y        = y_q[L];
    assign o_mask_rem = mask_q[L];
    assign o_chi      = chi_q[L];

    // Route each stage's input: the port for stage 0, and the previous stage register otherwise.
    always_comb begin
        found_in[0] = 1'b0;
        idx_in[0]   = '0;
        y_in[0]     = '0;
        mask_in[0]  = i_mask;
        chi_in[0]   = i_chi;
`ifdef PRIO_SEL_ROUND_ROBIN_EN
        ptr_in[0]   = ptr;
`else
        ptr_in[0]   = '0;
`endif
        for (int s = 1; s < STAGES; s++) begin
            found_in[s] = found_q[s-1];
            idx_in[s]   = idx_q[s-1];
            y_in[s]     = y_q[s-1];
            mask_in[s]  = mask_q[s-1];
            chi_in[s]   = chi_q[s-1];
`ifdef PRIO_SEL_ROUND_ROBIN_EN
            ptr_in[s]   = ptr_q[s-1];
`else
            ptr_in[s]   = '0;
`endif
        end
    end

    // Per-stage segment search. Position j is the rotated priority slot, and it maps to lane (ptr + j) mod M.
    always_comb begin
        logic            f;
        logic [IW-1:0]   ix;
        logic [N-1:0]    yy;
        logic [M-1:0]    mk;
        int              lane;
        f    = 1'b0;
        ix   = '0;
        yy   = '0;
        mk   = '0;
        lane = 0;
        for (int s = 0; s < STAGES; s++) begin
            f  = found_in[s];
            ix = idx_in[s];
            yy = y_in[s];
            mk = mask_in[s];
            for (int j = 0; j < M; j++) begin
                if (j / SEG == s) begin
                    lane = (int'(ptr_in[s]) + j) % M;
                    for (int k = 0; k < M; k++) begin
                        if (k == lane && !f && mk[k]) begin
                            f     = 1'b1;
                            ix    = IW'(k);
                            yy    = chi_in[s][k*N +: N];
                            mk[k] = 1'b0;
                        end
                    end
                end
            end
            found_d[s] = f;
            idx_d[s]   = ix;
            y_d[s]     = yy;
            mask_d[s]  = mk;
        end
    end

    // Whole-pipe shift on adv. Reset clears every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                v_q[s]     <= 1'b0;
                found_q[s] <= 1'b0;
                idx_q[s]   <= '0;
                y_q[s]     <= '0;
                mask_q[s]  <= '0;
                chi_q[s]   <= '0;
`ifdef PRIO_SEL_ROUND_ROBIN_EN
                ptr_q[s]   <= '0;
`endif
            end
        end else if (adv) begin
            v_q[0] <= i_valid;
            for (int s = 1; s < STAGES; s++) begin
                v_q[s] <= v_q[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                found_q[s] <= found_d[s];
                idx_q[s]   <= idx_d[s];
                y_q[s]     <= y_d[s];
                mask_q[s]  <= mask_d[s];
                chi_q[s]   <= chi_in[s];
`ifdef PRIO_SEL_ROUND_ROBIN_EN
                ptr_q[s]   <= ptr_in[s];
`endif
            end
        end
    end

`ifdef PRIO_SEL_ROUND_ROBIN_EN
    // Move the priority start just past the lane granted in the beat being handed off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (v_q[L] && o_ready && found_q[L]) begin
            ptr <= IW'((int'(idx_q[L]) + 1) % M);
        end
    end
`endif

endmodule
